// File: rtl/phy_rx_unstriper.sv
// Receive-side lane unstriper: locks onto a run of COM symbols, then deals data bytes
// round-robin into four lanes and pulses each completed (or COM-flushed) word for one cycle.
module phy_rx_unstriper #(
  parameter int            BW         = 8,
  parameter logic [BW-1:0] COM        = 8'hBC,
  parameter int            LOCK_COUNT = 4,
  parameter int            IDLE_MAX   = 8
) (
  input  logic          clk,
  input  logic          reset_L,
  input  logic [BW-1:0] data_in,
  input  logic          valid_in,
  output logic [BW-1:0] Out0,
  output logic [BW-1:0] Out1,
  output logic [BW-1:0] Out2,
  output logic [BW-1:0] Out3,
  output logic          valid0,
  output logic          valid1,
  output logic          valid2,
  output logic          valid3,
  output logic          locked
);

  localparam int CW = $clog2(LOCK_COUNT + 1);
  localparam int IW = $clog2(IDLE_MAX + 1);

  typedef enum logic {SEEK, LOCKED} state_t;

  state_t          state;
  logic [CW-1:0]   com_cnt;
  logic [IW-1:0]   idle_cnt;
  logic [1:0]      lane_ptr;
  logic [BW-1:0]   staging0, staging1, staging2;
  logic [BW-1:0]   out_q [4];
  logic [3:0]      valid_q;
  logic            locked_q;

  assign Out0   = out_q[0];
  assign Out1   = out_q[1];
  assign Out2   = out_q[2];
  assign Out3   = out_q[3];
  assign valid0 = valid_q[0];
  assign valid1 = valid_q[1];
  assign valid2 = valid_q[2];
  assign valid3 = valid_q[3];
  assign locked = locked_q;

  // Lane 3 never needs staging: its byte goes straight from data_in to Out3.
  always_ff @(posedge clk or negedge reset_L) begin
    if (!reset_L) begin
      state    <= SEEK;
      com_cnt  <= '0;
      idle_cnt <= '0;
      lane_ptr <= '0;
      staging0 <= '0;
      staging1 <= '0;
      staging2 <= '0;
      for (int k = 0; k < 4; k++) out_q[k] <= '0;
      valid_q  <= '0;
      locked_q <= 1'b0;
    end else begin
      valid_q <= '0;
      case (state)
        SEEK: begin
          if (valid_in) begin
            if (data_in == COM) begin
              if (com_cnt == CW'(LOCK_COUNT - 1)) begin
                state    <= LOCKED;
                locked_q <= 1'b1;
                com_cnt  <= '0;
                idle_cnt <= '0;
                lane_ptr <= '0;
              end else begin
                com_cnt <= com_cnt + 1'b1;
              end
            end else begin
              com_cnt <= '0;
            end
          end
        end

        LOCKED: begin
          if (valid_in) begin
            idle_cnt <= '0;
            if (data_in != COM) begin
              case (lane_ptr)
                2'd0: staging0 <= data_in;
                2'd1: staging1 <= data_in;
                2'd2: staging2 <= data_in;
                default: begin
                  out_q[0] <= staging0;
                  out_q[1] <= staging1;
                  out_q[2] <= staging2;
                  out_q[3] <= data_in;
                  valid_q  <= 4'hF;
                end
              endcase
              lane_ptr <= lane_ptr + 1'b1;
            end else if (lane_ptr != 2'd0) begin
              // COM mid-word flushes only the lanes already filled.
              out_q[0]   <= staging0;
              valid_q[0] <= 1'b1;
              if (lane_ptr >= 2'd2) begin
                out_q[1]   <= staging1;
                valid_q[1] <= 1'b1;
              end
              if (lane_ptr == 2'd3) begin
                out_q[2]   <= staging2;
                valid_q[2] <= 1'b1;
              end
              lane_ptr <= '0;
            end
          end else begin
            if (idle_cnt == IW'(IDLE_MAX - 1)) begin
              state    <= SEEK;
              locked_q <= 1'b0;
              com_cnt  <= '0;
              idle_cnt <= '0;
              lane_ptr <= '0;
            end else begin
              idle_cnt <= idle_cnt + 1'b1;
            end
          end
        end

        default: state <= SEEK;
      endcase
    end
  end

endmodule

// File: tb/tb_phy_rx_unstriper.sv
// Randomised scoreboard bench for phy_rx_unstriper: a queue-based lock/word model predicts
// every lane pulse and the locked flag; a negedge monitor compares whatever the DUT presents.
module tb_phy_rx_unstriper;

  localparam int          LOCK_COUNT = 4;
  localparam int          IDLE_MAX   = 8;
  localparam logic [7:0]  COM        = 8'hBC;

  logic       clk = 1'b0;
  logic       reset_L = 1'b0;
  logic [7:0] data_in = '0;
  logic       valid_in = 1'b0;
  logic [7:0] out0, out1, out2, out3;
  logic       valid0, valid1, valid2, valid3;
  logic       locked;

  phy_rx_unstriper #(
    .BW(8), .COM(COM), .LOCK_COUNT(LOCK_COUNT), .IDLE_MAX(IDLE_MAX)
  ) dut (
    .clk(clk), .reset_L(reset_L), .data_in(data_in), .valid_in(valid_in),
    .Out0(out0), .Out1(out1), .Out2(out2), .Out3(out3),
    .valid0(valid0), .valid1(valid1), .valid2(valid2), .valid3(valid3),
    .locked(locked)
  );

  always #5 clk = ~clk;

  typedef struct {
    int              cyc;
    logic [3:0]      mask;
    logic [3:0][7:0] outs;
  } exp_t;

  exp_t       exp_q[$];
  int         checks = 0;
  int         failures = 0;
  int         cyc = 0;
  logic       exp_locked = 1'b0;

  // Reference model state: lock flag, run lengths, bytes of the word in progress, last lane values.
  logic            m_locked;
  int              m_com_run;
  int              m_idle_run;
  logic [7:0]      m_partial[$];
  logic [3:0][7:0] m_last;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("[TB] FAIL %s actual=%0h required=%0h (t=%0t)", name, act, req, $time);
    end
  endtask

  task automatic model_reset();
    m_locked   = 1'b0;
    m_com_run  = 0;
    m_idle_run = 0;
    m_partial.delete();
    m_last     = '0;
    exp_q.delete();
    exp_locked = 1'b0;
  endtask

  task automatic model_emit(input int n);
    exp_t e;
    for (int k = 0; k < n; k++) m_last[k] = m_partial[k];
    e.cyc  = cyc + 1;
    e.mask = 4'((1 << n) - 1);
    e.outs = m_last;
    exp_q.push_back(e);
    m_partial.delete();
  endtask

  task automatic model_step(input logic v, input logic [7:0] d);
    if (!m_locked) begin
      if (v) begin
        if (d == COM) begin
          m_com_run++;
          if (m_com_run >= LOCK_COUNT) begin
            m_locked   = 1'b1;
            m_com_run  = 0;
            m_idle_run = 0;
            m_partial.delete();
          end
        end else begin
          m_com_run = 0;
        end
      end
    end else if (v) begin
      m_idle_run = 0;
      if (d != COM) begin
        m_partial.push_back(d);
        if (m_partial.size() == 4) model_emit(4);
      end else if (m_partial.size() > 0) begin
        model_emit(m_partial.size());
      end
    end else begin
      m_idle_run++;
      if (m_idle_run >= IDLE_MAX) begin
        m_locked  = 1'b0;
        m_com_run = 0;
        m_partial.delete();
        m_idle_run = 0;
      end
    end
  endtask

  // One clock of stimulus; inputs change 1 time unit after the rising edge.
  task automatic apply_stimulus(input logic v, input logic [7:0] d);
    valid_in = v;
    data_in  = d;
    if (reset_L) model_step(v, d);
    @(posedge clk);
    exp_locked = m_locked;
    #1;
  endtask

  task automatic send_coms(input int n);
    for (int i = 0; i < n; i++) apply_stimulus(1'b1, COM);
  endtask

  task automatic send_idles(input int n);
    for (int i = 0; i < n; i++) apply_stimulus(1'b0, $urandom_range(0, 255));
  endtask

  // Monitor: pops the scoreboard whenever any lane valid is presented.
  always @(negedge clk) begin
    if (!reset_L) begin
      check_output("reset_valid", {valid3, valid2, valid1, valid0}, 4'h0);
      check_output("reset_outs", {out3, out2, out1, out0}, 32'h0);
      check_output("reset_locked", locked, 1'b0);
    end else begin
      check_output("locked", locked, exp_locked);
      while (exp_q.size() > 0 && exp_q[0].cyc < cyc) begin
        check_output("missed_pulse_cycle", 32'(cyc), 32'(exp_q[0].cyc));
        void'(exp_q.pop_front());
      end
      if ({valid3, valid2, valid1, valid0} != 4'h0) begin
        if (exp_q.size() == 0 || exp_q[0].cyc != cyc) begin
          check_output("unexpected_pulse", {valid3, valid2, valid1, valid0}, 4'h0);
        end else begin
          exp_t e;
          e = exp_q.pop_front();
          check_output("valid_mask", {valid3, valid2, valid1, valid0}, e.mask);
          check_output("lane_outs", {out3, out2, out1, out0}, e.outs);
        end
      end
    end
  end

  initial begin
    int r;
    model_reset();

    // Reset held with random inputs, then released.
    reset_L = 1'b0;
    for (int i = 0; i < 6; i++) apply_stimulus($urandom_range(0, 1), $urandom_range(0, 255));
    reset_L = 1'b1;
    send_idles(2);

    // Broken COM run must not lock; the following full run must.
    send_coms(3);
    apply_stimulus(1'b1, 8'h11);
    send_coms(4);

    // Two back-to-back words.
    for (int i = 0; i < 8; i++) apply_stimulus(1'b1, 8'hA0 + 8'(i));
    send_idles(1);

    // Gapped partial word flushed by COM, then a fresh word from lane 0.
    apply_stimulus(1'b1, 8'h10);
    send_idles(3);
    apply_stimulus(1'b1, 8'h20);
    apply_stimulus(1'b1, COM);
    for (int i = 0; i < 4; i++) apply_stimulus(1'b1, 8'h30 + 8'(i));

    // Loss of lock, ignored byte, relock, word from lane 0.
    apply_stimulus(1'b1, 8'h55);
    send_idles(IDLE_MAX);
    apply_stimulus(1'b1, 8'h66);
    send_coms(4);
    for (int i = 0; i < 4; i++) apply_stimulus(1'b1, 8'h70 + 8'(i));

    // Async reset between edges in the middle of a word.
    apply_stimulus(1'b1, 8'h81);
    apply_stimulus(1'b1, 8'h82);
    #1;
    reset_L = 1'b0;
    model_reset();
    #1;
    check_output("async_reset_valid", {valid3, valid2, valid1, valid0}, 4'h0);
    check_output("async_reset_outs", {out3, out2, out1, out0}, 32'h0);
    check_output("async_reset_locked", locked, 1'b0);
    #1;
    reset_L = 1'b1;
    @(posedge clk);
    #1;
    send_idles(2);

    // Randomised traffic with occasional long idle bursts to exercise lock loss.
    for (int i = 0; i < 3000; i++) begin
      r = $urandom_range(0, 299);
      if (r == 0) begin
        send_idles(IDLE_MAX + 2);
      end else if (r < 45) begin
        apply_stimulus(1'b0, $urandom_range(0, 255));
      end else if (r < 100) begin
        apply_stimulus(1'b1, COM);
      end else begin
        apply_stimulus(1'b1, $urandom_range(0, 255));
      end
    end

    send_idles(3);
    check_output("pending_empty", 32'(exp_q.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
